// File: rtl/sprite_blit.sv
// Streams a W x H sprite from a synchronous colour ROM into the 160x120 frame buffer,
// one pixel per clock, dropping transparent and off-screen pixels.
module sprite_blit #(
  parameter int W           = 32,
  parameter int H           = 32,
  parameter int ADDR_W      = 10,
  parameter int COLOUR_W    = 3,
  parameter int TRANSPARENT = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [7:0]          xPos,
  input  logic [6:0]          yPos,
  output logic [ADDR_W-1:0]   romAddr,
  input  logic [COLOUR_W-1:0] romData,
  output logic [7:0]          xOut,
  output logic [6:0]          yOut,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0]          CX_LAST = 8'(W - 1);
  localparam logic [6:0]          CY_LAST = 7'(H - 1);
  localparam logic [COLOUR_W-1:0] TRANSP  = COLOUR_W'(TRANSPARENT);
  localparam logic [8:0]          SCREEN_W = 9'd160;
  localparam logic [7:0]          SCREEN_H = 8'd120;

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0]          r_x0;
  logic [6:0]          r_y0;
  logic [7:0]          r_cx;
  logic [6:0]          r_cy;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_vld;
  logic [8:0]          r_px;
  logic [7:0]          r_py;
  logic                w_accept;
  logic                w_row_end;
  logic                w_last;
  logic                w_on_screen;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_row_end = (r_cx == CX_LAST);
  assign w_last    = w_row_end && (r_cy == CY_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = DRAW;
      DRAW:    if (w_last) w_state_next = FLUSH;
      FLUSH:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Address stage: origin latch plus scan counters; romAddr runs as a plain counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x0   <= '0;
      r_y0   <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_x0   <= xPos;
      r_y0   <= yPos;
      r_cx   <= '0;
      r_cy   <= '0;
      r_addr <= '0;
    end else if (r_state == DRAW) begin
      r_addr <= r_addr + ADDR_W'(1);
      if (w_row_end) begin
        r_cx <= '0;
        r_cy <= r_cy + 7'd1;
      end else begin
        r_cx <= r_cx + 8'd1;
      end
    end
  end

  // Output stage lags the address by one cycle so it lines up with romData.
  // Coordinates are summed at full width so off-screen pixels clip rather than wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld <= 1'b0;
      r_px  <= '0;
      r_py  <= '0;
    end else begin
      r_vld <= (r_state == DRAW);
      if (r_state == DRAW) begin
        r_px <= {1'b0, r_x0} + {1'b0, r_cx};
        r_py <= {1'b0, r_y0} + {1'b0, r_cy};
      end
    end
  end

  assign w_on_screen = (r_px < SCREEN_W) && (r_py < SCREEN_H);

  assign romAddr = r_addr;
  assign xOut    = r_px[7:0];
  assign yOut    = r_py[6:0];
  assign colour  = romData;
  assign writeEn = r_vld && (romData != TRANSP) && w_on_screen;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_sprite_blit.sv
// Directed bench for sprite_blit: a 2x2 instance for sequencing/reset cases and a
// 4x2 instance placed at the bottom-right corner for clipping.
module tb_sprite_blit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic       start_a, start_b;
  logic [7:0] xpos_a, xpos_b;
  logic [6:0] ypos_a, ypos_b;
  logic [9:0] rom_addr_a, rom_addr_b;
  logic [2:0] rom_data_a, rom_data_b;
  logic [7:0] xout_a, xout_b;
  logic [6:0] yout_a, yout_b;
  logic [2:0] colour_a, colour_b;
  logic       we_a, we_b, busy_a, busy_b, done_a, done_b;

  logic [2:0] rom_a [0:15];
  logic [2:0] rom_b [0:15];

  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) rom_data_a <= rom_a[rom_addr_a[3:0]];
  always @(posedge clk) rom_data_b <= rom_b[rom_addr_b[3:0]];

  sprite_blit #(.W(2), .H(2), .ADDR_W(10), .COLOUR_W(3), .TRANSPARENT(0)) u_dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .xPos(xpos_a), .yPos(ypos_a),
    .romAddr(rom_addr_a), .romData(rom_data_a), .xOut(xout_a), .yOut(yout_a),
    .colour(colour_a), .writeEn(we_a), .busy(busy_a), .done(done_a)
  );

  sprite_blit #(.W(4), .H(2), .ADDR_W(10), .COLOUR_W(3), .TRANSPARENT(0)) u_dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .xPos(xpos_b), .yPos(ypos_b),
    .romAddr(rom_addr_b), .romData(rom_data_b), .xOut(xout_b), .yOut(yout_b),
    .colour(colour_b), .writeEn(we_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One 2x2 draw, checked cycle by cycle from cycle 0 (start) to cycle 7 (back in IDLE).
  // poke >= 0 pulses start with position (50,50) in that cycle; it must be ignored.
  task automatic draw22(input logic [2:0] p0, input logic [2:0] p1, input logic [2:0] p2,
                        input logic [2:0] p3, input logic [7:0] x, input logic [6:0] y,
                        input int poke);
    logic [2:0] pix [0:3];
    int         plots;
    pix = '{p0, p1, p2, p3};
    for (int i = 0; i < 4; i++) rom_a[i] = pix[i];
    plots = 0;
    @(negedge clk);
    xpos_a = x;
    ypos_a = y;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) @(negedge clk);
      start_a = (c == 0) || (c == poke);
      if (c == poke) begin
        xpos_a = 8'd50;
        ypos_a = 7'd50;
      end
      chk($sformatf("a_busy_c%0d", c), busy_a, (c >= 1 && c <= 6));
      chk($sformatf("a_done_c%0d", c), done_a, (c == 6));
      if (c >= 1 && c <= 4) chk($sformatf("a_addr_c%0d", c), rom_addr_a, c - 1);
      if (c >= 2 && c <= 5) begin
        int k;
        k = c - 2;
        chk($sformatf("a_we_c%0d", c), we_a, (pix[k] != 3'd0));
        if (pix[k] != 3'd0) begin
          plots++;
          chk($sformatf("a_x_c%0d", c), xout_a, x + 8'(k % 2));
          chk($sformatf("a_y_c%0d", c), yout_a, y + 7'(k / 2));
          chk($sformatf("a_col_c%0d", c), colour_a, pix[k]);
        end
      end else begin
        chk($sformatf("a_we_c%0d", c), we_a, 0);
      end
    end
    start_a = 1'b0;
    $display("draw 2x2 at (%0d,%0d) rom {%0d,%0d,%0d,%0d} poke=%0d plots=%0d",
             x, y, p0, p1, p2, p3, poke, plots);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    start_a = 1'b0; xpos_a = '0; ypos_a = '0;
    start_b = 1'b0; xpos_b = '0; ypos_b = '0;
    for (int i = 0; i < 16; i++) begin
      rom_a[i] = 3'd0;
      rom_b[i] = 3'd5;
    end
    repeat (3) @(negedge clk);

    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_we_a", we_a, 0);
    chk("rst_addr_a", rom_addr_a, 0);
    chk("rst_x_a", xout_a, 0);
    chk("rst_y_a", yout_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_we_b", we_b, 0);
    resetn = 1'b1;
    $display("reset released");

    draw22(3'd1, 3'd2, 3'd3, 3'd4, 8'd10, 7'd20, -1);
    draw22(3'd1, 3'd0, 3'd0, 3'd4, 8'd10, 7'd20, -1);
    draw22(3'd1, 3'd2, 3'd3, 3'd4, 8'd10, 7'd20, 3);

    // 4x2 at (158,118): columns 160/161 are clipped, both rows are on screen.
    @(negedge clk);
    xpos_b  = 8'd158;
    ypos_b  = 7'd118;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) @(negedge clk);
      start_b = (c == 0);
      chk($sformatf("b_busy_c%0d", c), busy_b, (c >= 1 && c <= 10));
      chk($sformatf("b_done_c%0d", c), done_b, (c == 10));
      if (c == 2 || c == 3 || c == 6 || c == 7) begin
        chk($sformatf("b_we_c%0d", c), we_b, 1);
        chk($sformatf("b_x_c%0d", c), xout_b, 158 + ((c - 2) % 4));
        chk($sformatf("b_y_c%0d", c), yout_b, 118 + ((c - 2) / 4));
      end else begin
        chk($sformatf("b_we_c%0d", c), we_b, 0);
      end
    end
    $display("draw 4x2 at (158,118) clipped to 4 plots");

    // Reset asserted mid-draw in cycle 3.
    rom_a[0] = 3'd1; rom_a[1] = 3'd2; rom_a[2] = 3'd3; rom_a[3] = 3'd4;
    @(negedge clk);
    xpos_a = 8'd10; ypos_a = 7'd20; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    chk("mid_we_c2", we_a, 1);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_we", we_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_x", xout_a, 0);
    chk("mid_rst_y", yout_a, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_we_%0d", c), we_a, 0);
      chk($sformatf("post_rst_busy_%0d", c), busy_a, 0);
    end
    $display("reset mid-draw: outputs cleared, no resume");
    draw22(3'd1, 3'd2, 3'd3, 3'd4, 8'd10, 7'd20, -1);

    // start held high: re-trigger every 7 cycles, address restarting at 0.
    @(negedge clk);
    xpos_a = 8'd10; ypos_a = 7'd20; start_a = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("hold_done_c%0d", c), done_a, (c == 6 || c == 13 || c == 20));
      chk($sformatf("hold_busy_c%0d", c), busy_a, (c % 7) != 0);
      if (c >= 1 && ((c - 1) % 7) <= 3) chk($sformatf("hold_addr_c%0d", c), rom_addr_a, (c - 1) % 7);
    end
    start_a = 1'b0;
    @(negedge clk);
    chk("hold_idle_busy", busy_a, 0);
    $display("start held: three draws completed");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
